// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RISC-V decode stage: decode, bypassed register file, load-use stall, ID/EX register
//
// Purpose: decodes the instruction held in IF/ID, reads two operands from an
// NREGS x XLEN register file (writeback data bypassed into same-cycle reads),
// detects load-use hazards against the instruction in EX and owns the ID/EX
// pipeline register.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   VALID_ID, PC_ID,    instruction presented by IF/ID
//   INSTRUCTION_ID
//   RegWrite_WB, RD_WB, register file write port from writeback
//   WB_DATA
//   FLUSH               branch taken in EX, squash the ID instruction
//   PCWrite,            0 = hold PC and IF/ID this cycle (load-use stall)
//   IF_ID_Write
//   *_EX                registered decode results, operands and controls
//   STALL_CNT           saturating count of load-use stall cycles
module id_stage_pipe #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             VALID_ID,
   input  logic [XLEN-1:0]  PC_ID,
   input  logic [31:0]      INSTRUCTION_ID,
   input  logic             RegWrite_WB,
   input  logic [4:0]       RD_WB,
   input  logic [XLEN-1:0]  WB_DATA,
   input  logic             FLUSH,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             VALID_EX,
   output logic             ILLEGAL_EX,
   output logic [XLEN-1:0]  PC_EX,
   output logic [XLEN-1:0]  REG_DATA1_EX,
   output logic [XLEN-1:0]  REG_DATA2_EX,
   output logic [XLEN-1:0]  IMM_EX,
   output logic [4:0]       RS1_EX,
   output logic [4:0]       RS2_EX,
   output logic [4:0]       RD_EX,
   output logic [2:0]       FUNCT3_EX,
   output logic [6:0]       FUNCT7_EX,
   output logic             RegWrite_EX,
   output logic             MemtoReg_EX,
   output logic             MemRead_EX,
   output logic             MemWrite_EX,
   output logic             ALUSrc_EX,
   output logic             Branch_EX,
   output logic [1:0]       ALUop_EX,
   output logic [CNT_W-1:0] STALL_CNT
);

   localparam int IDX_W = $clog2(NREGS);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Only 16- and 32-entry files exist, so bit 4 alone decides the range.
   function automatic logic in_range(input logic [4:0] idx);
      return (NREGS >= 32) || !idx[4];
   endfunction

   logic [XLEN-1:0] regs [NREGS];

   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   assign opcode = INSTRUCTION_ID[6:0];
   assign rs1    = INSTRUCTION_ID[19:15];
   assign rs2    = INSTRUCTION_ID[24:20];
   assign rd     = INSTRUCTION_ID[11:7];

   logic            known, rs2_used, rd_used, illegal;
   logic            regwrite, memtoreg, memread, memwrite, alusrc, branch;
   logic [1:0]      aluop;
   logic [XLEN-1:0] imm;

   always_comb begin
      known    = 1'b1;
      rs2_used = 1'b0;
      rd_used  = 1'b0;
      regwrite = 1'b0;
      memtoreg = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      alusrc   = 1'b0;
      branch   = 1'b0;
      aluop    = 2'b00;
      imm      = '0;
      case (opcode)
         OP_R: begin
            regwrite = 1'b1; aluop = 2'b10; rs2_used = 1'b1; rd_used = 1'b1;
         end
         OP_I_ALU: begin
            regwrite = 1'b1; alusrc = 1'b1; aluop = 2'b11; rd_used = 1'b1;
            imm = {{(XLEN-12){INSTRUCTION_ID[31]}}, INSTRUCTION_ID[31:20]};
         end
         OP_LOAD: begin
            regwrite = 1'b1; memread = 1'b1; memtoreg = 1'b1; alusrc = 1'b1;
            rd_used = 1'b1;
            imm = {{(XLEN-12){INSTRUCTION_ID[31]}}, INSTRUCTION_ID[31:20]};
         end
         OP_STORE: begin
            memwrite = 1'b1; alusrc = 1'b1; rs2_used = 1'b1;
            imm = {{(XLEN-12){INSTRUCTION_ID[31]}}, INSTRUCTION_ID[31:25],
                   INSTRUCTION_ID[11:7]};
         end
         OP_BRANCH: begin
            branch = 1'b1; aluop = 2'b01; rs2_used = 1'b1;
            imm = {{(XLEN-13){INSTRUCTION_ID[31]}}, INSTRUCTION_ID[31], INSTRUCTION_ID[7],
                   INSTRUCTION_ID[30:25], INSTRUCTION_ID[11:8], 1'b0};
         end
         default: known = 1'b0;
      endcase
      illegal = !known || !in_range(rs1) || (rs2_used && !in_range(rs2)) ||
                (rd_used && !in_range(rd));
   end

   // Writeback forwards into the read in the same cycle; indices outside a
   // reduced file read as zero rather than aliasing onto a lower register.
   logic            bypass1, bypass2;
   logic [XLEN-1:0] rdata1, rdata2;
   assign bypass1 = RegWrite_WB && (RD_WB != 5'd0) && (RD_WB == rs1);
   assign bypass2 = RegWrite_WB && (RD_WB != 5'd0) && (RD_WB == rs2);
   assign rdata1  = (rs1 == 5'd0 || !in_range(rs1)) ? '0 :
                    bypass1 ? WB_DATA : regs[rs1[IDX_W-1:0]];
   assign rdata2  = (rs2 == 5'd0 || !in_range(rs2)) ? '0 :
                    bypass2 ? WB_DATA : regs[rs2[IDX_W-1:0]];

   logic hazard, stall, bubble;
   assign hazard = VALID_EX && MemRead_EX && (RD_EX != 5'd0) && VALID_ID &&
                   ((RD_EX == rs1) || (rs2_used && (RD_EX == rs2)));
   // A taken branch discards the dependent instruction, so no stall is needed.
   assign stall       = hazard && !FLUSH;
   assign bubble      = FLUSH || !VALID_ID || hazard;
   assign PCWrite     = !stall;
   assign IF_ID_Write = !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (RegWrite_WB && (RD_WB != 5'd0) && in_range(RD_WB)) begin
         regs[RD_WB[IDX_W-1:0]] <= WB_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         VALID_EX     <= 1'b0;
         ILLEGAL_EX   <= 1'b0;
         PC_EX        <= '0;
         REG_DATA1_EX <= '0;
         REG_DATA2_EX <= '0;
         IMM_EX       <= '0;
         RS1_EX       <= '0;
         RS2_EX       <= '0;
         RD_EX        <= '0;
         FUNCT3_EX    <= '0;
         FUNCT7_EX    <= '0;
         RegWrite_EX  <= 1'b0;
         MemtoReg_EX  <= 1'b0;
         MemRead_EX   <= 1'b0;
         MemWrite_EX  <= 1'b0;
         ALUSrc_EX    <= 1'b0;
         Branch_EX    <= 1'b0;
         ALUop_EX     <= 2'b00;
      end else begin
         // Illegal instructions still travel as valid so EX can trap on them,
         // but with every control cleared.
         VALID_EX     <= 1'b1;
         ILLEGAL_EX   <= illegal;
         PC_EX        <= PC_ID;
         REG_DATA1_EX <= rdata1;
         REG_DATA2_EX <= rdata2;
         IMM_EX       <= imm;
         RS1_EX       <= rs1;
         RS2_EX       <= rs2;
         RD_EX        <= rd;
         FUNCT3_EX    <= INSTRUCTION_ID[14:12];
         FUNCT7_EX    <= INSTRUCTION_ID[31:25];
         RegWrite_EX  <= regwrite && !illegal;
         MemtoReg_EX  <= memtoreg && !illegal;
         MemRead_EX   <= memread  && !illegal;
         MemWrite_EX  <= memwrite && !illegal;
         ALUSrc_EX    <= alusrc   && !illegal;
         Branch_EX    <= branch   && !illegal;
         ALUop_EX     <= illegal ? 2'b00 : aluop;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         STALL_CNT <= '0;
      end else if (stall && (STALL_CNT != '1)) begin
         STALL_CNT <= STALL_CNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - bench for id_stage_pipe (32-reg/16-bit counter and 16-reg/2-bit counter instances)
module tb_id_stage_pipe;

   localparam int NT = 2;

   localparam logic [31:0] ADD_X3  = 32'h002081B3;  // add  x3,x1,x2
   localparam logic [31:0] ADDI_X6 = 32'hFFF28313;  // addi x6,x5,-1
   localparam logic [31:0] ADD_X7A = 32'h000283B3;  // add  x7,x5,x0
   localparam logic [31:0] LW_X4   = 32'h0000A203;  // lw   x4,0(x1)
   localparam logic [31:0] ADD_X7  = 32'h004203B3;  // add  x7,x4,x4
   localparam logic [31:0] LW_X0   = 32'h0000A003;  // lw   x0,0(x1)
   localparam logic [31:0] ADD_X00 = 32'h000003B3;  // add  x7,x0,x0
   localparam logic [31:0] BEQ_M8  = 32'hFE208CE3;  // beq  x1,x2,-8
   localparam logic [31:0] SW_12   = 32'h0020A623;  // sw   x2,12(x1)
   localparam logic [31:0] ADD_X20 = 32'h00208A33;  // add  x20,x1,x2
   localparam logic [31:0] RD_X20  = 32'h000A00B3;  // add  x1,x20,x0
   localparam logic [31:0] BAD_OP  = 32'h0000007F;

   typedef struct packed {
      logic        valid, illegal;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        regwrite, memtoreg, memread, memwrite, alusrc, branch;
      logic [1:0]  aluop;
   } ex_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, valid_id, rw_wb, flush;
   logic [31:0] pc_id, inst_id, wb_data;
   logic [4:0]  rd_wb;

   logic        pcw [NT], ifw [NT], valid_ex [NT], illegal_ex [NT];
   logic        regwrite_ex [NT], memtoreg_ex [NT], memread_ex [NT];
   logic        memwrite_ex [NT], alusrc_ex [NT], branch_ex [NT];
   logic [31:0] pc_ex [NT], d1_ex [NT], d2_ex [NT], imm_ex [NT];
   logic [4:0]  rs1_ex [NT], rs2_ex [NT], rd_ex [NT];
   logic [2:0]  f3_ex [NT];
   logic [6:0]  f7_ex [NT];
   logic [1:0]  aluop_ex [NT];
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   id_stage_pipe #(.XLEN(32), .NREGS(32), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .VALID_ID(valid_id), .PC_ID(pc_id),
      .INSTRUCTION_ID(inst_id), .RegWrite_WB(rw_wb), .RD_WB(rd_wb), .WB_DATA(wb_data),
      .FLUSH(flush), .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]), .VALID_EX(valid_ex[0]),
      .ILLEGAL_EX(illegal_ex[0]), .PC_EX(pc_ex[0]), .REG_DATA1_EX(d1_ex[0]),
      .REG_DATA2_EX(d2_ex[0]), .IMM_EX(imm_ex[0]), .RS1_EX(rs1_ex[0]), .RS2_EX(rs2_ex[0]),
      .RD_EX(rd_ex[0]), .FUNCT3_EX(f3_ex[0]), .FUNCT7_EX(f7_ex[0]),
      .RegWrite_EX(regwrite_ex[0]), .MemtoReg_EX(memtoreg_ex[0]), .MemRead_EX(memread_ex[0]),
      .MemWrite_EX(memwrite_ex[0]), .ALUSrc_EX(alusrc_ex[0]), .Branch_EX(branch_ex[0]),
      .ALUop_EX(aluop_ex[0]), .STALL_CNT(cnt_a));

   id_stage_pipe #(.XLEN(32), .NREGS(16), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .VALID_ID(valid_id), .PC_ID(pc_id),
      .INSTRUCTION_ID(inst_id), .RegWrite_WB(rw_wb), .RD_WB(rd_wb), .WB_DATA(wb_data),
      .FLUSH(flush), .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]), .VALID_EX(valid_ex[1]),
      .ILLEGAL_EX(illegal_ex[1]), .PC_EX(pc_ex[1]), .REG_DATA1_EX(d1_ex[1]),
      .REG_DATA2_EX(d2_ex[1]), .IMM_EX(imm_ex[1]), .RS1_EX(rs1_ex[1]), .RS2_EX(rs2_ex[1]),
      .RD_EX(rd_ex[1]), .FUNCT3_EX(f3_ex[1]), .FUNCT7_EX(f7_ex[1]),
      .RegWrite_EX(regwrite_ex[1]), .MemtoReg_EX(memtoreg_ex[1]), .MemRead_EX(memread_ex[1]),
      .MemWrite_EX(memwrite_ex[1]), .ALUSrc_EX(alusrc_ex[1]), .Branch_EX(branch_ex[1]),
      .ALUop_EX(aluop_ex[1]), .STALL_CNT(cnt_b));

   ex_t act [NT];
   int  act_cnt [NT];
   always_comb begin
      for (int k = 0; k < NT; k++) begin
         act[k] = '{valid: valid_ex[k], illegal: illegal_ex[k], pc: pc_ex[k], d1: d1_ex[k],
                    d2: d2_ex[k], imm: imm_ex[k], rs1: rs1_ex[k], rs2: rs2_ex[k],
                    rd: rd_ex[k], f3: f3_ex[k], f7: f7_ex[k], regwrite: regwrite_ex[k],
                    memtoreg: memtoreg_ex[k], memread: memread_ex[k],
                    memwrite: memwrite_ex[k], alusrc: alusrc_ex[k],
                    branch: branch_ex[k], aluop: aluop_ex[k]};
      end
      act_cnt[0] = int'(cnt_a);
      act_cnt[1] = int'(cnt_b);
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: architectural register contents, expected ID/EX
   // contents and stall count for each instance.
   logic [31:0] m_regs [NT][32];
   ex_t         m_ex [NT];
   int          m_cnt [NT];
   int          nregs_of [NT] = '{32, 16};
   int          cmax [NT]     = '{65535, 3};

   function automatic bit uses_rs2(input logic [6:0] op);
      return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
   endfunction

   function automatic logic [7:0] ctl(input ex_t e);
      return {e.regwrite, e.memtoreg, e.memread, e.memwrite, e.alusrc, e.branch, e.aluop};
   endfunction

   function automatic logic [31:0] m_read(input int k, input logic [4:0] idx);
      if (idx == 0 || int'(idx) >= nregs_of[k]) return 32'd0;
      if (rw_wb && rd_wb == idx) return wb_data;
      return m_regs[k][idx];
   endfunction

   function automatic ex_t m_decode(input int k);
      ex_t  e = '0;
      logic [6:0] op = inst_id[6:0];
      logic [4:0] r1 = inst_id[19:15];
      logic [4:0] r2 = inst_id[24:20];
      logic [4:0] rd = inst_id[11:7];
      bit   known = 1, ud = 0;
      int   v = 0;
      case (op)
         7'b0110011: begin e.regwrite = 1; e.aluop = 2; ud = 1; end
         7'b0010011: begin e.regwrite = 1; e.alusrc = 1; e.aluop = 3; ud = 1;
                           v = int'(inst_id[31:20]); if (v >= 2048) v -= 4096; end
         7'b0000011: begin e.regwrite = 1; e.memread = 1; e.memtoreg = 1; e.alusrc = 1; ud = 1;
                           v = int'(inst_id[31:20]); if (v >= 2048) v -= 4096; end
         7'b0100011: begin e.memwrite = 1; e.alusrc = 1;
                           v = int'(inst_id[31:25]) * 32 + int'(inst_id[11:7]);
                           if (v >= 2048) v -= 4096; end
         7'b1100011: begin e.branch = 1; e.aluop = 1;
                           v = int'(inst_id[31]) * 4096 + int'(inst_id[7]) * 2048 +
                               int'(inst_id[30:25]) * 32 + int'(inst_id[11:8]) * 2;
                           if (v >= 4096) v -= 8192; end
         default: known = 0;
      endcase
      e.imm = 32'(v);
      e.illegal = !known || int'(r1) >= nregs_of[k] ||
                  (uses_rs2(op) && int'(r2) >= nregs_of[k]) || (ud && int'(rd) >= nregs_of[k]);
      if (e.illegal) begin
         e.regwrite = 0; e.memtoreg = 0; e.memread = 0; e.memwrite = 0;
         e.alusrc = 0; e.branch = 0; e.aluop = 0;
      end
      e.valid = 1; e.pc = pc_id; e.rs1 = r1; e.rs2 = r2; e.rd = rd;
      e.f3 = inst_id[14:12]; e.f7 = inst_id[31:25];
      e.d1 = m_read(k, r1); e.d2 = m_read(k, r2);
      return e;
   endfunction

   function automatic bit m_hazard(input int k);
      return m_ex[k].valid && m_ex[k].memread && m_ex[k].rd != 0 && valid_id &&
             (m_ex[k].rd == inst_id[19:15] ||
              (uses_rs2(inst_id[6:0]) && m_ex[k].rd == inst_id[24:20]));
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w = $urandom;
      logic [6:0]  ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
      int          sel = int'($urandom_range(0, 5));
      if (sel < 5) w[6:0] = ops[sel];
      if ($urandom_range(0, 3) != 0) w[19:15] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) w[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) w[11:7]  = 5'($urandom_range(0, 7));
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] inst);
      valid_id = v;
      inst_id  = inst;
      pc_id    = pc_id + 32'd4;
   endtask

   task automatic do_reset();
      reset = 1'b1; valid_id = 1'b0; rw_wb = 1'b0; flush = 1'b0;
      rd_wb = 5'd0; wb_data = 32'd0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; valid_id = 1'b1; inst_id = ADD_X3; pc_id = 32'h100;
      rw_wb = 1'b0; rd_wb = 5'd0; wb_data = 32'd0; flush = 1'b0;
      tick();
      reset = 1'b0; valid_id = 1'b0;
      #1;
      n_tests++;
      if (act[0] !== '0 || act[1] !== '0) begin
         n_fail++; $display("FAIL reset_idex actual=%h/%h required=0", act[0], act[1]);
      end
      n_tests++;
      if (cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
         n_fail++; $display("FAIL reset_cnt actual=%0d/%0d required=0", cnt_a, cnt_b);
      end
      n_tests++;
      if (pcw[0] !== 1'b1 || ifw[0] !== 1'b1) begin
         n_fail++; $display("FAIL reset_pcwrite actual=%b%b required=11", pcw[0], ifw[0]);
      end
   endtask

   task automatic test_add();
      set_id(1'b1, ADD_X3);
      tick();
      n_tests++;
      if (valid_ex[0] !== 1'b1 || regwrite_ex[0] !== 1'b1 || aluop_ex[0] !== 2'b10 ||
          rs1_ex[0] !== 5'd1 || rs2_ex[0] !== 5'd2 || rd_ex[0] !== 5'd3 || illegal_ex[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL add_decode actual v=%b rw=%b op=%b rs1=%0d rs2=%0d rd=%0d required v=1 rw=1 op=10 rs1=1 rs2=2 rd=3",
                  valid_ex[0], regwrite_ex[0], aluop_ex[0], rs1_ex[0], rs2_ex[0], rd_ex[0]);
      end
   endtask

   task automatic test_bypass();
      set_id(1'b1, ADDI_X6);
      rw_wb = 1'b1; rd_wb = 5'd5; wb_data = 32'hDEADBEEF;
      tick();
      rw_wb = 1'b0;
      n_tests++;
      if (d1_ex[0] !== 32'hDEADBEEF || imm_ex[0] !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL bypass_addi actual data1=%h imm=%h required DEADBEEF FFFFFFFF",
                            d1_ex[0], imm_ex[0]);
      end
      set_id(1'b1, ADD_X7A);
      tick();
      n_tests++;
      if (d1_ex[0] !== 32'hDEADBEEF || d1_ex[1] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL regfile_read actual=%h/%h required DEADBEEF", d1_ex[0], d1_ex[1]);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, LW_X4);
      tick();
      set_id(1'b1, ADD_X7);
      #1;
      n_tests++;
      if (pcw[0] !== 1'b0 || ifw[0] !== 1'b0) begin
         n_fail++; $display("FAIL stall_pcwrite actual=%b%b required=00", pcw[0], ifw[0]);
      end
      tick();
      n_tests++;
      if (valid_ex[0] !== 1'b0 || memread_ex[0] !== 1'b0 || regwrite_ex[0] !== 1'b0 || cnt_a !== 16'd1) begin
         n_fail++; $display("FAIL stall_bubble actual v=%b mr=%b cnt=%0d required v=0 mr=0 cnt=1",
                            valid_ex[0], memread_ex[0], cnt_a);
      end
      n_tests++;
      if (pcw[0] !== 1'b1) begin
         n_fail++; $display("FAIL stall_release actual=%b required=1", pcw[0]);
      end
      tick();
      n_tests++;
      if (valid_ex[0] !== 1'b1 || rd_ex[0] !== 5'd7 || rs1_ex[0] !== 5'd4 || cnt_a !== 16'd1) begin
         n_fail++; $display("FAIL add_after_stall actual v=%b rd=%0d rs1=%0d cnt=%0d required 1 7 4 1",
                            valid_ex[0], rd_ex[0], rs1_ex[0], cnt_a);
      end
      set_id(1'b1, LW_X0);
      tick();
      set_id(1'b1, ADD_X00);
      #1;
      n_tests++;
      if (pcw[0] !== 1'b1) begin
         n_fail++; $display("FAIL x0_no_stall actual=%b required=1", pcw[0]);
      end
      tick();
      n_tests++;
      if (valid_ex[0] !== 1'b1 || cnt_a !== 16'd1) begin
         n_fail++; $display("FAIL x0_issue actual v=%b cnt=%0d required v=1 cnt=1", valid_ex[0], cnt_a);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1'b1, LW_X4);
      tick();
      set_id(1'b1, ADD_X7);
      flush = 1'b1;
      #1;
      n_tests++;
      if (pcw[0] !== 1'b1 || ifw[0] !== 1'b1) begin
         n_fail++; $display("FAIL flush_pcwrite actual=%b%b required=11", pcw[0], ifw[0]);
      end
      tick();
      flush = 1'b0;
      n_tests++;
      if (act[0] !== '0 || cnt_a !== 16'd0) begin
         n_fail++; $display("FAIL flush_bubble actual=%h cnt=%0d required=0 cnt=0", act[0], cnt_a);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1'b1, LW_X4);
      tick();
      set_id(1'b1, ADD_X7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_tests++;
      if (act[0] !== '0 || cnt_a !== 16'd0 || pcw[0] !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_stall actual=%h cnt=%0d pcw=%b required=0 cnt=0 pcw=1",
                            act[0], cnt_a, pcw[0]);
      end
   endtask

   task automatic test_branch_store();
      set_id(1'b1, BEQ_M8);
      tick();
      n_tests++;
      if (branch_ex[0] !== 1'b1 || aluop_ex[0] !== 2'b01 || imm_ex[0] !== 32'hFFFFFFF8 ||
          regwrite_ex[0] !== 1'b0) begin
         n_fail++; $display("FAIL beq_decode actual br=%b op=%b imm=%h required br=1 op=01 imm=FFFFFFF8",
                            branch_ex[0], aluop_ex[0], imm_ex[0]);
      end
      set_id(1'b1, SW_12);
      tick();
      n_tests++;
      if (memwrite_ex[0] !== 1'b1 || alusrc_ex[0] !== 1'b1 || imm_ex[0] !== 32'd12 ||
          aluop_ex[0] !== 2'b00) begin
         n_fail++; $display("FAIL sw_decode actual mw=%b src=%b imm=%h required mw=1 src=1 imm=0000000C",
                            memwrite_ex[0], alusrc_ex[0], imm_ex[0]);
      end
      set_id(1'b1, BAD_OP);
      tick();
      n_tests++;
      if (illegal_ex[0] !== 1'b1 || valid_ex[0] !== 1'b1 || ctl(act[0]) !== 8'd0) begin
         n_fail++; $display("FAIL bad_opcode actual ill=%b v=%b ctl=%h required ill=1 v=1 ctl=00",
                            illegal_ex[0], valid_ex[0], ctl(act[0]));
      end
   endtask

   task automatic test_nregs16();
      do_reset();
      set_id(1'b1, ADD_X20);
      tick();
      n_tests++;
      if (illegal_ex[1] !== 1'b1 || ctl(act[1]) !== 8'd0 || illegal_ex[0] !== 1'b0 ||
          regwrite_ex[0] !== 1'b1) begin
         n_fail++; $display("FAIL x20_illegal actual ill16=%b ctl16=%h ill32=%b rw32=%b required 1 00 0 1",
                            illegal_ex[1], ctl(act[1]), illegal_ex[0], regwrite_ex[0]);
      end
      set_id(1'b0, ADD_X3);
      rw_wb = 1'b1; rd_wb = 5'd20; wb_data = 32'h12345678;
      tick();
      rw_wb = 1'b0;
      set_id(1'b1, RD_X20);
      tick();
      n_tests++;
      if (d1_ex[0] !== 32'h12345678 || illegal_ex[1] !== 1'b1 || d1_ex[1] !== 32'd0) begin
         n_fail++; $display("FAIL x20_read actual d32=%h ill16=%b d16=%h required 12345678 1 00000000",
                            d1_ex[0], illegal_ex[1], d1_ex[1]);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int s = 0; s < 4; s++) begin
         set_id(1'b1, LW_X4);
         tick();
         set_id(1'b1, ADD_X7);
         tick();
         tick();
      end
      n_tests++;
      if (cnt_b !== 2'd3 || cnt_a !== 16'd4) begin
         n_fail++; $display("FAIL stall_saturate actual cnt2=%0d cnt16=%0d required 3 4", cnt_b, cnt_a);
      end
   endtask

   task automatic test_random(input int n);
      ex_t nxt [NT];
      bit  hz;
      do_reset();
      for (int k = 0; k < NT; k++) begin
         m_ex[k] = '0; m_cnt[k] = 0;
         for (int i = 0; i < 32; i++) m_regs[k][i] = 32'd0;
      end
      for (int c = 0; c < n; c++) begin
         valid_id = ($urandom_range(0, 7) != 0);
         flush    = ($urandom_range(0, 7) == 0);
         inst_id  = rand_inst();
         pc_id    = $urandom;
         rw_wb    = ($urandom_range(0, 1) == 1);
         rd_wb    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wb_data  = $urandom;
         #1;
         for (int k = 0; k < NT; k++) begin
            hz = m_hazard(k) && !flush;
            n_tests++;
            if (pcw[k] !== !hz || ifw[k] !== !hz) begin
               n_fail++; $display("FAIL rand_pcwrite[%0d] cyc=%0d actual=%b%b required=%b",
                                  k, c, pcw[k], ifw[k], !hz);
            end
            nxt[k] = (flush || !valid_id || m_hazard(k)) ? ex_t'('0) : m_decode(k);
            if (hz && m_cnt[k] < cmax[k]) m_cnt[k]++;
            if (rw_wb && rd_wb != 0 && int'(rd_wb) < nregs_of[k]) m_regs[k][rd_wb] = wb_data;
         end
         tick();
         for (int k = 0; k < NT; k++) begin
            m_ex[k] = nxt[k];
            n_tests++;
            if (act[k] !== m_ex[k] || act_cnt[k] != m_cnt[k]) begin
               n_fail++; $display("FAIL rand_idex[%0d] cyc=%0d actual=%h cnt=%0d required=%h cnt=%0d",
                                  k, c, act[k], act_cnt[k], m_ex[k], m_cnt[k]);
            end
         end
      end
      valid_id = 1'b0; flush = 1'b0; rw_wb = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_bypass();
      test_load_use();
      test_flush();
      test_reset_mid_stall();
      test_branch_store();
      test_nregs16();
      test_saturate();
      test_random(600);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised RISC-V decode stage for the 5-stage pipeline, sitting between the IF/ID register and EX. It decodes the instruction and reads a register file with write-through bypass. It detects load-use hazards, stalling IF/ID and injecting a bubble, and owns the ID/EX pipeline register. Supports RV32I/RV64I datapath width and RV32E-style reduced register files.

## Interface
- XLEN, 32, datapath width (32 or 64); register data, PC and immediate widths
- NREGS, 32, architectural registers (16 or 32); index width fixed at 5 bits
- CNT_W, 16, width of the stall performance counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- VALID_ID  in  1  IF/ID holds a real instruction
- PC_ID  in  XLEN  PC of instruction in ID
- INSTRUCTION_ID  in  32  instruction in ID
- RegWrite_WB  in  1  writeback enable
- RD_WB  in  5  writeback destination
- WB_DATA  in  XLEN  writeback data
- FLUSH  in  1  branch taken in EX; squash ID
- PCWrite, IF_ID_Write  out  1  0 = hold PC / IF/ID (stall)
- VALID_EX, ILLEGAL_EX  out  1  ID/EX valid; illegal-instruction marker
- PC_EX, REG_DATA1_EX, REG_DATA2_EX, IMM_EX  out  XLEN  registered operands
- RS1_EX, RS2_EX, RD_EX  out  5  registered register indices
- FUNCT3_EX  out  3; FUNCT7_EX  out  7  registered function fields
- RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX  out  1  registered controls
- ALUop_EX  out  2  registered ALU class
- STALL_CNT  out  CNT_W  count of load-use stall cycles, saturating

## Operation
- Decode by opcode. R 0110011: RegWrite, ALUop=10. I-ALU 0010011: RegWrite, ALUSrc, ALUop=11. Load 0000011: RegWrite, MemRead, MemtoReg, ALUSrc, ALUop=00. Store 0100011: MemWrite, ALUSrc, ALUop=00. Branch 1100011: Branch, ALUop=01.
- Any other opcode: all controls 0, ILLEGAL set.
- Immediate: I-type (loads, I-ALU) = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}. All sign-extended to XLEN. Other opcodes: 0.
- rs1 is used by all five classes; rs2 only by R, store and branch.
- Register file: NREGS x XLEN. Written on clk when RegWrite_WB and RD_WB!=0 and RD_WB<NREGS. x0 reads 0.
- Read bypass: if RegWrite_WB && RD_WB!=0 && RD_WB==rsN, the read returns WB_DATA in the same cycle.
- NREGS=16: any used rs1/rs2/rd index ≥16 makes the instruction illegal. Controls are forced to 0 and ILLEGAL set.
- Load-use hazard: VALID_EX && MemRead_EX && RD_EX!=0 && VALID_ID && (RD_EX==rs1, or RD_EX==rs2 with rs2 used).
  - On hazard: PCWrite=IF_ID_Write=0; ID/EX loads a bubble (VALID_EX=0, all controls 0); STALL_CNT+1, saturating at all-ones.
- FLUSH has priority over the hazard. ID/EX loads a bubble, PCWrite=IF_ID_Write=1, and STALL_CNT is unchanged.
- VALID_ID=0: bubble loaded; no hazard is raised.
- Normal case: ID/EX captures the decoded fields, operands and controls; VALID_EX=1.

## Timing
- The ID/EX register has 1-cycle latency. Outputs change only on the rising edge of clk.
- PCWrite and IF_ID_Write are combinational from the current ID/EX contents and the ID instruction.
- A load-use stall lasts exactly 1 cycle. After the bubble, MemRead_EX=0, so the instruction advances on the next edge.
- Register write and same-cycle read of the same index: the read returns the new data via bypass. The array is updated at the edge.
- Reset (synchronous, active-high, priority over everything):
  - All ID/EX outputs are 0, including VALID_EX and ILLEGAL_EX.
  - STALL_CNT is 0.
  - Register file is cleared to 0.
  - PCWrite=IF_ID_Write=1 in the cycle after reset.
  - Reset asserted mid-stall cancels the stall.

## Test plan
- Reset, then decode add x3,x1,x2 (0x002081B3) with VALID_ID=1 → next cycle VALID_EX=1, RegWrite_EX=1, ALUop_EX=10, RS1_EX=1, RS2_EX=2, RD_EX=3.
- Write x5=0xDEADBEEF via WB while decoding addi x6,x5,-1 in the same cycle → REG_DATA1_EX=0xDEADBEEF, IMM_EX=all-ones (bypass and sign extension).
- lw x4,0(x1) followed by add x7,x4,x4:
  - 1 cycle with PCWrite=IF_ID_Write=0 and a bubble in EX, then the add issues.
  - STALL_CNT=1.
  - With x0 as the load rd: no stall.
- Load-use hazard coincident with FLUSH=1 → bubble in EX, PCWrite=1, STALL_CNT unchanged.
- NREGS=16: add x20,x1,x2 → ILLEGAL_EX=1, all controls 0. Writeback to x20 is ignored; a subsequent read of x20 is not performed (illegal).
- beq x1,x2,-8 → Branch_EX=1, ALUop_EX=01, IMM_EX=-8. Store sw x2,12(x1) → MemWrite_EX=1, IMM_EX=12. Saturate STALL_CNT with CNT_W=2 after 4 stalls → holds at 3.
